// File: rtl/rx_pkg.sv
// Shared receive-path definitions: default word width, collector state
// encoding and the helper that sizes the bit counter.
package rx_pkg;

  localparam int DESER_WIDTH_DEFAULT = 8;

  typedef enum logic {
    DS_IDLE    = 1'b0,
    DS_COLLECT = 1'b1
  } deser_state_t;

  // Counter width for a WIDTH-bit word; never narrower than one bit.
  function automatic int deser_cnt_width(input int width);
    return ($clog2(width) < 1) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/word_hold_reg.sv
// Single-entry registered valid/ready output stage; full mirrors outValid
// so the collector can stall only the word-completing bit.
module word_hold_reg #(
  parameter int W = 8
) (
  input  logic         inClk,
  input  logic         inRstN,
  input  logic         load,
  input  logic [W-1:0] loadData,
  input  logic         outReady,
  output logic         outValid,
  output logic [W-1:0] outData,
  output logic         full
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  // A load in the same cycle as a consume replaces the word and keeps valid set.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = loadData;
    end else if (valid_q && outReady) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge inClk or negedge inRstN) begin
    if (!inRstN) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign outValid = valid_q;
  assign outData  = data_q;
  assign full     = valid_q;

endmodule

// File: rtl/bit_deserializer.sv
// Serial-to-parallel deserializer: collects WIDTH bits per word through a
// valid/ready bit interface and hands finished words to word_hold_reg.
module bit_deserializer
  import rx_pkg::*;
#(
  parameter int WIDTH     = DESER_WIDTH_DEFAULT,
  parameter bit LSB_FIRST = 1'b1,
  localparam int CW       = deser_cnt_width(WIDTH)
) (
  input  logic             inClk,
  input  logic             inRstN,
  input  logic             inBit,
  input  logic             inValid,
  input  logic             inStart,
  output logic             inReady,
  output logic [WIDTH-1:0] outData,
  output logic             outValid,
  input  logic             outReady,
  output logic [CW-1:0]    outSel,
  output logic             outDrop,
  output deser_state_t     dbgState
);

  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] word_q, word_d;
  deser_state_t     state_q, state_d;
  logic             drop_q, drop_d;
  logic             accept;
  logic             load;
  logic [WIDTH-1:0] load_word;
  logic             full;
  logic [CW-1:0]    bit_idx;
  logic [CW-1:0]    bit_pos;

  // Only the completing bit waits for the output register to drain.
  assign inReady = !((cnt_q == LAST) && full && !outReady);
  assign accept  = inValid && inReady;

  always_comb begin
    cnt_d     = cnt_q;
    word_d    = word_q;
    state_d   = state_q;
    drop_d    = 1'b0;
    load      = 1'b0;
    load_word = word_q;
    bit_idx   = inStart ? '0 : cnt_q;
    bit_pos   = LSB_FIRST ? bit_idx : (LAST - bit_idx);
    if (accept) begin
      if (inStart) begin
        word_d = '0;
      end
      word_d[bit_pos] = inBit;
      if (inStart) begin
        // Resync: this bit is index 0; anything partial is thrown away.
        cnt_d   = CW'(1);
        state_d = DS_COLLECT;
        drop_d  = (cnt_q != '0);
      end else if (cnt_q == LAST) begin
        cnt_d     = '0;
        state_d   = DS_IDLE;
        load      = 1'b1;
        load_word = word_d;
      end else begin
        cnt_d   = cnt_q + CW'(1);
        state_d = DS_COLLECT;
      end
    end
  end

  always_ff @(posedge inClk or negedge inRstN) begin
    if (!inRstN) begin
      cnt_q   <= '0;
      word_q  <= '0;
      state_q <= DS_IDLE;
      drop_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      state_q <= state_d;
      drop_q  <= drop_d;
    end
  end

  word_hold_reg #(
    .W(WIDTH)
  ) u_hold (
    .inClk    (inClk),
    .inRstN   (inRstN),
    .load     (load),
    .loadData (load_word),
    .outReady (outReady),
    .outValid (outValid),
    .outData  (outData),
    .full     (full)
  );

  assign outSel   = cnt_q;
  assign outDrop  = drop_q;
  assign dbgState = state_q;

endmodule

// File: tb/tb_bit_deserializer.sv
// Bench for bit_deserializer: an LSB-first and an MSB-first instance share
// one stimulus stream and are checked against a bit-list reference model.
module tb_bit_deserializer;
  import rx_pkg::*;

  localparam int W  = 8;
  localparam int CW = 3;

  logic clk = 1'b0;
  logic rst_n;
  logic in_bit, in_valid, in_start, out_ready;

  logic         ready_l, valid_l, drop_l;
  logic [W-1:0] data_l;
  logic [CW-1:0] sel_l;
  deser_state_t st_l;
  logic         ready_m, valid_m, drop_m;
  logic [W-1:0] data_m;
  logic [CW-1:0] sel_m;
  deser_state_t st_m;

  bit_deserializer #(.WIDTH(W), .LSB_FIRST(1'b1)) dut_l (
    .inClk(clk), .inRstN(rst_n), .inBit(in_bit), .inValid(in_valid),
    .inStart(in_start), .inReady(ready_l), .outData(data_l),
    .outValid(valid_l), .outReady(out_ready), .outSel(sel_l),
    .outDrop(drop_l), .dbgState(st_l)
  );

  bit_deserializer #(.WIDTH(W), .LSB_FIRST(1'b0)) dut_m (
    .inClk(clk), .inRstN(rst_n), .inBit(in_bit), .inValid(in_valid),
    .inStart(in_start), .inReady(ready_m), .outData(data_m),
    .outValid(valid_m), .outReady(out_ready), .outSel(sel_m),
    .outDrop(drop_m), .dbgState(st_m)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model / scoreboard ----------------
  // Valid/ready: a bit moves when inValid && inReady at a rising edge; a word
  // moves when outValid && outReady at a rising edge.
  logic         mbits[$];
  logic [W-1:0] exp_l[$];
  logic [W-1:0] exp_m[$];
  logic         exp_drop;
  logic         last_acc;
  int           checks;
  int           failures;
  int           cyc;
  int           vld_cyc[$];

  task automatic model_clear();
    mbits.delete();
    exp_l.delete();
    exp_m.delete();
    exp_drop = 1'b0;
  endtask

  // One clock: entered and left at a falling edge with inputs already driven.
  task automatic tick();
    logic         exp_rdy, acc, cons;
    logic [W-1:0] wl, wm;
    deser_state_t exp_st;
    #1;
    exp_rdy = !((mbits.size() == W - 1) && (exp_l.size() != 0) && !out_ready);
    checks++;
    if (ready_l !== exp_rdy || ready_m !== exp_rdy) begin
      failures++;
      $display("FAIL in_ready cyc=%0d got=%b/%b exp=%b", cyc, ready_l, ready_m, exp_rdy);
    end
    acc  = in_valid && exp_rdy;
    cons = (exp_l.size() != 0) && out_ready;
    @(posedge clk);
    if (cons) begin
      void'(exp_l.pop_front());
      void'(exp_m.pop_front());
    end
    exp_drop = 1'b0;
    if (acc) begin
      if (in_start) begin
        exp_drop = (mbits.size() != 0);
        mbits.delete();
      end
      mbits.push_back(in_bit);
      if (mbits.size() == W) begin
        wl = '0;
        wm = '0;
        for (int i = 0; i < W; i++) begin
          wl[i]         = mbits[i];
          wm[W - 1 - i] = mbits[i];
        end
        exp_l.push_back(wl);
        exp_m.push_back(wm);
        mbits.delete();
      end
    end
    last_acc = acc;
    cyc++;
    @(negedge clk);
    checks++;
    if (valid_l !== (exp_l.size() != 0) || valid_m !== (exp_m.size() != 0)) begin
      failures++;
      $display("FAIL out_valid cyc=%0d got=%b/%b exp=%b", cyc, valid_l, valid_m, exp_l.size() != 0);
    end
    checks++;
    if (sel_l !== CW'(mbits.size()) || sel_m !== CW'(mbits.size())) begin
      failures++;
      $display("FAIL out_sel cyc=%0d got=%0d/%0d exp=%0d", cyc, sel_l, sel_m, mbits.size());
    end
    checks++;
    if (drop_l !== exp_drop || drop_m !== exp_drop) begin
      failures++;
      $display("FAIL out_drop cyc=%0d got=%b/%b exp=%b", cyc, drop_l, drop_m, exp_drop);
    end
    exp_st = (mbits.size() != 0) ? DS_COLLECT : DS_IDLE;
    checks++;
    if (st_l !== exp_st || st_m !== exp_st) begin
      failures++;
      $display("FAIL state cyc=%0d got=%0d/%0d exp=%0d", cyc, st_l, st_m, exp_st);
    end
    if (exp_l.size() != 0) begin
      checks++;
      if (data_l !== exp_l[0] || data_m !== exp_m[0]) begin
        failures++;
        $display("FAIL out_data cyc=%0d got=%h/%h exp=%h/%h", cyc, data_l, data_m, exp_l[0], exp_m[0]);
      end
    end
    if (valid_l) vld_cyc.push_back(cyc);
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_bit(input logic b, input logic s, output int waits);
    in_valid = 1'b1;
    in_bit   = b;
    in_start = s;
    waits    = 0;
    do begin
      tick();
      waits++;
    end while (!last_acc && waits < 50);
    checks++;
    if (!last_acc) begin
      failures++;
      $display("FAIL bit_accept_timeout got=0 exp=1");
    end
    in_start = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    in_start = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send_word(input logic [W-1:0] w, output int total);
    int wt;
    total = 0;
    for (int i = 0; i < W; i++) begin
      drive_bit(w[i], 1'b0, wt);
      total += wt;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    checks++;
    if (valid_l !== 1'b0 || data_l !== '0 || sel_l !== '0 || drop_l !== 1'b0 ||
        ready_l !== 1'b1 || valid_m !== 1'b0 || data_m !== '0 || ready_m !== 1'b1) begin
      failures++;
      $display("FAIL reset_values got v=%b d=%h s=%0d dr=%b r=%b exp v=0 d=00 s=0 dr=0 r=1",
               valid_l, data_l, sel_l, drop_l, ready_l);
    end
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    in_valid  = 1'b0;
    in_bit    = 1'b0;
    in_start  = 1'b0;
    out_ready = 1'b1;
    rst_n     = 1'b1;
    @(negedge clk);
    do_reset();
    idle(2);
  endtask

  task automatic test_single();
    logic [W-1:0] w;
    int tot;
    w = 8'b0000_0101;
    out_ready = 1'b1;
    send_word(w, tot);
    checks++;
    if (data_l !== 8'h05 || data_m !== 8'hA0 || valid_l !== 1'b1) begin
      failures++;
      $display("FAIL single_word got=%h/%h v=%b exp=05/a0 v=1", data_l, data_m, valid_l);
    end
    in_valid = 1'b0;
    tick();
    checks++;
    if (valid_l !== 1'b0 || sel_l !== '0) begin
      failures++;
      $display("FAIL single_pulse got v=%b sel=%0d exp v=0 sel=0", valid_l, sel_l);
    end
    idle(2);
  endtask

  task automatic test_back_to_back();
    int t1, t2;
    out_ready = 1'b1;
    vld_cyc.delete();
    send_word(8'hA5, t1);
    send_word(8'h3C, t2);
    idle(2);
    checks++;
    if (t1 + t2 != 2 * W) begin
      failures++;
      $display("FAIL b2b_stall got=%0d cycles exp=%0d", t1 + t2, 2 * W);
    end
    checks++;
    if (vld_cyc.size() != 2 || (vld_cyc[1] - vld_cyc[0]) != W) begin
      failures++;
      $display("FAIL b2b_spacing got=%0d pulses exp=2 pulses %0d apart", vld_cyc.size(), W);
    end
  endtask

  task automatic test_backpressure();
    int tot, wt;
    logic [W-1:0] w2;
    w2 = 8'h3C;
    out_ready = 1'b1;
    send_word(8'hA5, tot);
    out_ready = 1'b0;
    for (int i = 0; i < W - 1; i++) drive_bit(w2[i], 1'b0, wt);
    in_valid = 1'b1;
    in_bit   = w2[W-1];
    tick();
    tick();
    checks++;
    if (last_acc !== 1'b0 || ready_l !== 1'b0 || data_l !== 8'hA5) begin
      failures++;
      $display("FAIL bp_stall got acc=%b rdy=%b d=%h exp acc=0 rdy=0 d=a5", last_acc, ready_l, data_l);
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if (last_acc !== 1'b1 || data_l !== 8'h3C || valid_l !== 1'b1) begin
      failures++;
      $display("FAIL bp_release got acc=%b d=%h v=%b exp acc=1 d=3c v=1", last_acc, data_l, valid_l);
    end
    idle(2);
  endtask

  task automatic test_resync();
    logic [W-1:0] w;
    int wt;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) drive_bit(1'($urandom_range(0, 1)), 1'b0, wt);
    w = W'($urandom);
    drive_bit(w[0], 1'b1, wt);
    checks++;
    if (drop_l !== 1'b1 || sel_l !== CW'(1)) begin
      failures++;
      $display("FAIL resync_drop got drop=%b sel=%0d exp drop=1 sel=1", drop_l, sel_l);
    end
    for (int i = 1; i < W; i++) drive_bit(w[i], 1'b0, wt);
    checks++;
    if (data_l !== w || valid_l !== 1'b1) begin
      failures++;
      $display("FAIL resync_word got=%h exp=%h", data_l, w);
    end
    idle(2);
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] w;
    int tot, wt;
    out_ready = 1'b0;
    send_word(W'($urandom), tot);
    for (int i = 0; i < 5; i++) drive_bit(1'($urandom_range(0, 1)), 1'b0, wt);
    in_valid = 1'b0;
    do_reset();
    tick();
    checks++;
    if (drop_l !== 1'b0 || valid_l !== 1'b0 || sel_l !== '0) begin
      failures++;
      $display("FAIL reset_mid got drop=%b v=%b sel=%0d exp 0/0/0", drop_l, valid_l, sel_l);
    end
    out_ready = 1'b1;
    w = W'($urandom);
    send_word(w, tot);
    checks++;
    if (data_l !== w) begin
      failures++;
      $display("FAIL reset_mid_word got=%h exp=%h", data_l, w);
    end
    idle(2);
  endtask

  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_bit    = 1'($urandom_range(0, 1));
      in_start  = ($urandom_range(0, 15) == 0);
      out_ready = ($urandom_range(0, 2) != 0);
      tick();
    end
    out_ready = 1'b1;
    idle(3);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    cyc      = 0;
    last_acc = 1'b0;
    model_clear();
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_resync();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bit_deserializer.md
# bit_deserializer

Serial-to-parallel deserializer that rebuilds words from a bit stream. It is the receive-side counterpart of the parallel-to-serial multiplexers (MUX211/MUX414/MUX811) used on the transmit path. It sits between the chip/symbol demapper and the byte-level PHY receive logic. It accepts one bit per valid/ready handshake, assembles WIDTH bits, and presents the completed word through a one-entry registered valid/ready output.

## Interface
- WIDTH, 8: bits per output word; a power of two, at least 2.
- LSB_FIRST, 1: 1 = first received bit goes to outData[0]; 0 = first received bit goes to outData[WIDTH-1].
- inClk  in  1  clock; all state updates on the rising edge.
- inRstN  in  1  asynchronous active-low reset.
- inBit  in  1  serial data bit.
- inValid  in  1  inBit is valid this cycle.
- inStart  in  1  qualified by inValid; the accepted bit is bit 0 of a new word.
- inReady  out  1  deserializer accepts a bit this cycle (combinational).
- outData  out  WIDTH  completed word (registered).
- outValid  out  1  outData holds an unconsumed word.
- outReady  in  1  downstream consumes outData when outValid is high.
- outSel  out  clog2(WIDTH)  index of the next bit to be written; mirrors the transmit-side mux select.
- outDrop  out  1  one-cycle pulse when a partial word is discarded by inStart.

## Operation
- Bit accept: inValid && inReady.
- Collector holds a shift/index register and a bit counter cnt (clog2(WIDTH) bits); outSel = cnt.
- LSB_FIRST=1: accepted bit is written to word[cnt]. LSB_FIRST=0: accepted bit is written to word[WIDTH-1-cnt].
- cnt increments on each accept and wraps from WIDTH-1 to 0. On the wrap, the word, including the current bit, is transferred to the output register.
- Collector states:
  - IDLE (cnt==0, nothing partial): an accept goes to COLLECT.
  - COLLECT: an accept with cnt==WIDTH-1 completes the word and returns to IDLE.
- inStart on an accept: cnt is forced so that the accepted bit is index 0 and the next cnt is 1.
  - If cnt!=0 at that moment, the partial word is discarded and outDrop pulses on the next cycle.
  - inStart in IDLE produces no drop.
  - When WIDTH=... every case: inStart never completes a word unless WIDTH would be 1, which is disallowed.
- Output register is a single entry with outValid as its full flag.
  - Consume: outValid && outReady clears outValid, unless a new word loads in the same cycle. In that case outValid stays 1 and outData takes the new word.
- inReady = !(cnt==WIDTH-1 && outValid && !outReady). Only the completing bit is stalled; bits 0..WIDTH-2 are always accepted.
- inValid low: no state change; the partial word is held indefinitely.
- No words are lost or duplicated under any outReady pattern.

## Timing
- Reset values: outData=0, outValid=0, outSel=0, outDrop=0. inReady=1 while reset is asserted and after reset.
- Internal word register is cleared by reset.
- Latency: outValid rises on the edge that accepts the last bit, so it is visible the cycle after that accept.
- Throughput: one word every WIDTH accepted bits, with no bubble when outReady is held high.
- Simultaneous consume and complete: the new word replaces the old one and outValid stays 1.
- Simultaneous inStart and completion cannot occur: inStart resets cnt to 1.
- Reset asserted mid-word or with outValid=1: everything returns to reset values immediately, with no outDrop pulse. The first accepted bit after release is index 0.
- outData is stable while outValid && !outReady.

## Structure
- Shared package rx_pkg holds:
  - localparam DESER_WIDTH_DEFAULT=8.
  - typedef enum {DS_IDLE, DS_COLLECT} deser_state_t.
  - The clog2-derived counter width as a function.
- One sub-module is natural: word_hold_reg.
  - Purpose: the single-entry valid/ready output register.
  - Ports: load, loadData, outReady, outValid, outData, and a full flag used for inReady.
- The collector and counter stay in bit_deserializer.

## Test plan
- Single word, WIDTH=8, LSB_FIRST=1, outReady=1: bits 1,0,1,0,0,0,0,0 -> outData=8'h05; outValid high one cycle after the 8th accept, for exactly one cycle; outSel steps 0..7 then 0.
- Same bits with LSB_FIRST=0 -> outData=8'hA0.
- Back-to-back, outReady=1, bits of 8'hA5 then 8'h3C (LSB first) with inValid held high -> two outValid pulses 8 cycles apart with 8'hA5 then 8'h3C; inReady never low.
- Backpressure: outReady=0 after the first word 8'hA5; stream the second word 8'h3C.
  - Bits 0..6 are accepted; inReady drops at the 8th bit; outData stays 8'hA5.
  - One cycle after outReady=1, the 8th bit is accepted; then outData=8'h3C.
- Resync: after 3 accepted bits, accept a bit with inStart=1 -> outDrop pulses once; outSel=1; the following 7 bits complete a correct word.
- Reset mid-word: after 5 bits with a held word, pulse inRstN low -> outValid=0, outSel=0, outData=0, no outDrop; the next 8 bits give the expected word.
